// File: rtl/enc_pkg.sv
// enc_pkg: shared types, opcodes and immediate limits for the RV32I instruction encoder.
// The ENC_LI_EN macro adds the LI_HI/LI_LO states used by the LI expansion.
package enc_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_LI, FMT_RSV} fmt_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_RANGE, ERR_ALIGN, ERR_FMT} err_e;
`ifdef ENC_LI_EN
  typedef enum logic [1:0] {EMPTY, FULL, LI_HI, LI_LO} state_e;
`else
  typedef enum logic {EMPTY, FULL} state_e;
`endif
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN = -4096;
  localparam int IMMB_MAX = 4094;
  localparam int IMMJ_MIN = -1048576;
  localparam int IMMJ_MAX = 1048574;
  function automatic logic in_range(logic [31:0] v, int lo, int hi);
    return $signed(v) >= lo && $signed(v) <= hi;
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational scatter of (fmt, fields, imm) into a 32-bit RV32I word.
// Ports: i_fmt/i_opcode/i_funct3/i_funct7/i_rd/i_rs1/i_rs2/i_imm in, o_word out; LI and reserved formats pack to zero.
module instr_pack
  import enc_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word
);
  always_comb begin
    o_word = '0;
    case (i_fmt)
      FMT_R: o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      FMT_I: o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      FMT_S: o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      FMT_B: o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
      FMT_U: o_word = {i_imm[31:12], i_rd, i_opcode};
      FMT_J: o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: o_word = '0;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I encoder with range/alignment checks and a wrapping word address.
// Ports: in_* request (valid/ready), out_* word stream (valid/ready, instr, addr), err pulse and held err_code.
// Define ENC_LI_EN to support fmt 6 (LI), expanded into LUI+ADDI when the value exceeds 12 bits.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code
);
  state_e r_state, w_state_nxt;
  logic [31:0] r_instr, w_word, w_imm;
  logic [ADDR_W-1:0] r_addr;
  logic r_err, w_acc, w_hs, w_bad;
  err_e r_err_code, w_code;
  fmt_e w_fmt;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [4:0] w_rs1;
`ifdef ENC_LI_EN
  logic [31:0] r_lo, w_lo;
  logic [19:0] w_hi;
  logic w_split, w_two;
  // Rounding hi up when imm[11] is set compensates for ADDI sign-extending its 12 bits.
  assign w_hi = in_imm[31:12] + {19'd0, in_imm[11]};
  assign w_lo = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_OPIMM};
  assign w_two = w_split && |in_imm[11:0];
  assign in_ready = !out_valid || (out_ready && r_state != LI_HI);
`else
  assign in_ready = !out_valid || out_ready;
`endif
  assign out_valid = r_state != EMPTY;
  assign out_instr = r_instr;
  assign out_addr = r_addr;
  assign err = r_err;
  assign err_code = r_err_code;
  assign w_acc = in_valid && in_ready;
  assign w_hs = out_valid && out_ready;
  assign w_bad = w_code == ERR_FMT;
  always_comb begin
    w_fmt = fmt_e'(in_fmt);
    w_op = in_opcode;
    w_f3 = in_funct3;
    w_rs1 = in_rs1;
    w_imm = in_imm;
    w_code = ERR_NONE;
`ifdef ENC_LI_EN
    w_split = 1'b0;
`endif
    case (fmt_e'(in_fmt))
      FMT_R: w_code = ERR_NONE;
      FMT_I, FMT_S: w_code = in_range(in_imm, IMM12_MIN, IMM12_MAX) ? ERR_NONE : ERR_RANGE;
      FMT_B: w_code = in_imm[0] ? ERR_ALIGN : in_range(in_imm, IMMB_MIN, IMMB_MAX) ? ERR_NONE : ERR_RANGE;
      FMT_J: w_code = in_imm[0] ? ERR_ALIGN : in_range(in_imm, IMMJ_MIN, IMMJ_MAX) ? ERR_NONE : ERR_RANGE;
      FMT_U: w_code = |in_imm[11:0] ? ERR_RANGE : ERR_NONE;
`ifdef ENC_LI_EN
      FMT_LI: begin
        w_split = !in_range(in_imm, IMM12_MIN, IMM12_MAX);
        w_fmt = w_split ? FMT_U : FMT_I;
        w_op = w_split ? OP_LUI : OP_OPIMM;
        w_f3 = 3'b000;
        w_rs1 = 5'd0;
        w_imm = w_split ? {w_hi, 12'h000} : in_imm;
      end
`endif
      default: w_code = ERR_FMT;
    endcase
  end
  instr_pack u_pack (
    .i_fmt(w_fmt),
    .i_opcode(w_op),
    .i_funct3(w_f3),
    .i_funct7(in_funct7),
    .i_rd(in_rd),
    .i_rs1(w_rs1),
    .i_rs2(in_rs2),
    .i_imm(w_imm),
    .o_word(w_word)
  );
  // A bad-format acceptance implies the held word (if any) left this cycle, so the slot empties.
  always_comb begin
    w_state_nxt = r_state;
`ifdef ENC_LI_EN
    if (w_acc) w_state_nxt = w_bad ? EMPTY : w_two ? LI_HI : FULL;
    else if (w_hs) w_state_nxt = r_state == LI_HI ? LI_LO : EMPTY;
`else
    if (w_acc) w_state_nxt = w_bad ? EMPTY : FULL;
    else if (w_hs) w_state_nxt = EMPTY;
`endif
  end
  // err is registered, so it pulses alongside the word produced by the faulty request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_instr <= '0;
      r_addr <= ADDR_W'(BASE_ADDR);
      r_err <= 1'b0;
      r_err_code <= ERR_NONE;
`ifdef ENC_LI_EN
      r_lo <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_err <= w_acc && w_code != ERR_NONE;
      if (w_hs) r_addr <= r_addr + ADDR_W'(1);
      if (w_acc) r_err_code <= w_code;
      if (w_acc && !w_bad) r_instr <= w_word;
`ifdef ENC_LI_EN
      else if (w_hs && r_state == LI_HI) r_instr <= r_lo;
      if (w_acc) r_lo <= w_lo;
`endif
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a queue-based reference model checked every cycle.
module tb_instr_encoder;
  localparam int AW = 2;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, err;
  logic [2:0] in_fmt = 0, in_funct3 = 0;
  logic [6:0] in_opcode = 0, in_funct7 = 0;
  logic [4:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0;
  logic [31:0] in_imm = 0, out_instr;
  logic [AW-1:0] out_addr;
  logic [1:0] err_code;
  int total = 0, bad = 0;
  logic [31:0] q[$];
  int m_addr = 0, m_code = 0;
  logic m_err = 0;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endfunction

  function automatic void ref_enc(input logic [2:0] f, input logic [31:0] op, f3, f7, rd, rs1, rs2, imm,
                                  output logic [31:0] w0, output logic [31:0] w1, output int n, output int c);
    int s;
    s = $signed(imm);
    w0 = 0; w1 = 0; n = 1; c = 0;
    case (f)
      3'd0: w0 = f7 << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
      3'd1: begin
        w0 = (imm & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | op;
        c = (s < -2048 || s > 2047) ? 1 : 0;
      end
      3'd2: begin
        w0 = ((imm >> 5) & 32'h7F) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12 | (imm & 32'h1F) << 7 | op;
        c = (s < -2048 || s > 2047) ? 1 : 0;
      end
      3'd3: begin
        w0 = ((imm >> 12) & 1) << 31 | ((imm >> 5) & 32'h3F) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
           | ((imm >> 1) & 32'hF) << 8 | ((imm >> 11) & 1) << 7 | op;
        c = imm[0] ? 2 : (s < -4096 || s > 4094) ? 1 : 0;
      end
      3'd4: begin
        w0 = (imm & 32'hFFFFF000) | rd << 7 | op;
        c = (imm & 32'hFFF) != 0 ? 1 : 0;
      end
      3'd5: begin
        w0 = ((imm >> 20) & 1) << 31 | ((imm >> 1) & 32'h3FF) << 21 | ((imm >> 11) & 1) << 20
           | ((imm >> 12) & 32'hFF) << 12 | rd << 7 | op;
        c = imm[0] ? 2 : (s < -1048576 || s > 1048574) ? 1 : 0;
      end
`ifdef ENC_LI_EN
      3'd6: begin
        if (s >= -2048 && s <= 2047) w0 = (imm & 32'hFFF) << 20 | rd << 7 | 32'h13;
        else begin
          w0 = ((imm + 32'h800) & 32'hFFFFF000) | rd << 7 | 32'h37;
          if ((imm & 32'hFFF) != 0) begin
            w1 = (imm & 32'hFFF) << 20 | rd << 15 | rd << 7 | 32'h13;
            n = 2;
          end
        end
      end
`endif
      default: begin n = 0; c = 3; end
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    logic [31:0] w0, w1;
    int n, c;
    if (rst) begin
      q.delete();
      m_addr = 0; m_code = 0; m_err = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || (out_ready && q.size() == 1)));
      chk("out_addr", 32'(out_addr), 32'(m_addr));
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
      if (out_valid && q.size() != 0) chk("out_instr", out_instr, q[0]);
      if (out_valid && out_ready) begin
        if (q.size() != 0) void'(q.pop_front());
        m_addr = (m_addr + 1) % (1 << AW);
      end
      m_err = 0;
      if (in_valid && in_ready) begin
        ref_enc(in_fmt, 32'(in_opcode), 32'(in_funct3), 32'(in_funct7), 32'(in_rd), 32'(in_rs1),
                32'(in_rs2), in_imm, w0, w1, n, c);
        if (n >= 1) q.push_back(w0);
        if (n == 2) q.push_back(w1);
        m_err = c != 0;
        m_code = c;
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit ok = 0;
    in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout got=0 want=1");
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = !out_valid;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout got=1 want=0");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [31:0] w0, w1, held;
    int n, c;
    ref_enc(3'd1, 32'h13, 0, 0, 1, 0, 0, 32'd5, w0, w1, n, c);
    chk("pin_addi5", w0, 32'h00500093);
    ref_enc(3'd3, 32'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC, w0, w1, n, c);
    chk("pin_beq_m4", w0, 32'hFE208EE3);
    ref_enc(3'd3, 32'h63, 0, 0, 0, 1, 2, 32'd3, w0, w1, n, c);
    chk("pin_beq_3", w0, 32'h00208163);
    chk("pin_beq_3_code", 32'(c), 32'd2);
    ref_enc(3'd7, 32'h13, 0, 0, 1, 0, 0, 32'd0, w0, w1, n, c);
    chk("pin_fmt7_code", 32'(c), 32'd3);
`ifdef ENC_LI_EN
    ref_enc(3'd6, 0, 0, 0, 5, 0, 0, 32'h12345FFF, w0, w1, n, c);
    chk("pin_li_hi", w0, 32'h123462B7);
    chk("pin_li_lo", w1, 32'hFFF28293);
    ref_enc(3'd6, 0, 0, 0, 5, 0, 0, 32'h00010000, w0, w1, n, c);
    chk("pin_li_one", 32'(n), 32'd1);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_instr", out_instr, 32'h0);
    @(posedge clk); #1;

    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    chk("addi5_word", out_instr, 32'h00500093);
    chk("addi5_addr", 32'(out_addr), 32'd0);
    @(posedge clk); #1;
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    @(negedge clk);
    chk("beq3_err", 32'(err), 32'd1);
    chk("beq3_code", 32'(err_code), 32'd2);
    @(posedge clk); #1;
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd6, 5'd7, 32'hFFFFF800);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4094);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    send(3'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFF000);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'h12345000);
    send(3'd4, 7'h17, 3'd0, 7'd0, 5'd8, 5'd0, 5'd0, 32'h12345001);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h000FFFFE);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00010000);
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    drain();

    out_ready = 0;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 32'd100);
    held = out_instr;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", out_instr, held);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    drain();

    send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    @(negedge clk);
    chk("fmt7_valid", 32'(out_valid), 32'd0);
    chk("fmt7_code", 32'(err_code), 32'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) send(3'd1, 7'h13, 3'd0, 7'd0, 5'(i), 5'd0, 5'd0, 32'(i * 3));
    drain();

    out_ready = 0;
`ifdef ENC_LI_EN
    send(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
`else
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd9);
`endif
    rst = 1;
    @(posedge clk);
    #1 rst = 0; out_ready = 1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_addr", 32'(out_addr), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder: the inverse of the immediate decode path. Accepts a decoded request (format, opcode, funct fields, register indices, signed 32-bit immediate), scatters the immediate into the correct bit positions, range- and alignment-checks it, and emits 32-bit instruction words with a sequential word address. It sits in front of instruction memory as the program loader and self-test stimulus source. It optionally expands a load-immediate pseudo-op into LUI+ADDI.

## Interface
- ADDR_W, 10, width of the word address counter
- BASE_ADDR, 0, word address of the first emitted instruction

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_fmt  in  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 LI, 7 reserved
- in_opcode  in  7  opcode field; ignored for LI
- in_funct3  in  3  funct3; ignored for U, J, LI
- in_funct7  in  7  funct7; R only
- in_rd, in_rs1, in_rs2  in  5 each  register indices; unused fields ignored
- in_imm  in  32  signed immediate; byte offset for B/J; full 32-bit value for U and LI
- out_valid  out  1  out_instr valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_instr
- err  out  1  one-cycle pulse on the acceptance cycle of a faulty request
- err_code  out  2  0 none, 1 range, 2 misaligned, 3 bad format; held until next acceptance

## Operation
- Field packing: R = funct7|rs2|rs1|f3|rd|op; I = imm[11:0]|rs1|f3|rd|op; S = imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; U = imm[31:12]|rd|op; J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range rules: I/S −2048..2047; B −4096..4094; J −1048576..1048574; U requires imm[11:0]==0.
- Alignment: B and J require imm[0]==0. Alignment is checked before range; only one code is reported.
- Range or alignment fault: word is still emitted with truncated bits; err pulses; err_code set.
- Bad format (7, or 6 without LI support): nothing emitted, address unchanged, err pulses, err_code=3.
- LI: imm in −2048..2047 → single ADDI rd,x0,imm (0010011, f3 000).
  - Otherwise LUI rd,hi with hi=(imm+0x800)[31:12], followed by ADDI rd,rd,imm[11:0].
  - ADDI is omitted when imm[11:0]==0.
- FSM states:
  - EMPTY: no word held.
  - FULL: one word held.
  - LI_HI: LUI held, ADDI pending.
  - LI_LO: ADDI held.
- FSM transitions:
  - LI_HI → LI_LO on an output handshake.
  - LI_LO and FULL behave identically.
- out_addr: starts at BASE_ADDR; increments by 1 on each output handshake; wraps modulo 2^ADDR_W, with no flag on wrap.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, err 0, err_code 0, state EMPTY. in_ready is 1 in the first cycle after reset.
- Latency: accepted request appears on out_instr the next cycle.
- Throughput: one word per cycle.
- in_ready = !out_valid || (out_ready && state != LI_HI). The expansion stalls input for exactly one extra handshake.
- Backpressure: while out_valid && !out_ready, out_instr, out_addr and state hold stable.
- Simultaneous output handshake and new acceptance: the new word loads and the address advances in the same cycle.
- Reset mid-operation: any pending ADDI half is discarded and all outputs return to reset values.

## Configuration
- ENC_LI_EN defined: fmt 6 is supported, and the LI_HI state and hi-rounding adder are present.
- ENC_LI_EN undefined: fmt 6 is rejected with err_code=3. The FSM reduces to EMPTY and FULL.

## Structure
- Package enc_pkg contains:
  - format code enum;
  - opcode constants OP_LUI 0110111, OP_OPIMM 0010011;
  - immediate range limits;
  - err_code enum.
- Sub-module instr_pack holds the combinational field scatter for (fmt, fields, imm) → 32-bit word. It is instantiated once.
- The FSM, range checks and address counter live in instr_encoder.

## Test plan
- fmt I, op 0010011, f3 0, rd 1, rs1 0, imm 5 → next cycle out_instr 0x00500093, out_addr 0, err 0.
- fmt B, op 1100011, f3 0, rs1 1, rs2 2, imm −4 → out_instr 0xFE208EE3. Repeat with imm 3 → word emitted, err pulse, err_code 2.
- LI rd 5, imm 0x12345FFF (ENC_LI_EN) → out_instr 0x123462B7 at addr 0, then 0xFFF28293 at addr 1; in_ready low while LUI is held. Repeat with LI imm 0x00010000 → only 0x000102B7 is emitted.
- Hold out_ready 0 for 3 cycles with out_valid 1 → out_instr and out_addr stable, in_ready 0, no word lost or duplicated.
- fmt 7 request → no out_valid, address unchanged, err pulse, err_code 3.
- ADDR_W 2: emit 5 I-type words → addresses 0,1,2,3,0. Assert rst after the LUI half of an LI is accepted → out_valid 0, out_addr BASE_ADDR next cycle, and ADDI is never emitted.
